// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller and its lane aligner.
package dmem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SIZE_B    = 2'b00;
    localparam logic [1:0] SIZE_H    = 2'b01;
    localparam logic [1:0] SIZE_W    = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Request attributes carried alongside the read word until the response is formed.
    typedef struct packed {
        logic       load;
        logic       fault;
        logic [1:0] size;
        logic       uns;
        logic [1:0] lane;
    } rsp_meta_t;

    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lane[0];
            SIZE_W:  return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and the misalignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]       req_size,
    input  logic [1:0]       req_lane,
    input  logic [31:0]      req_wdata,
    output logic [LANES-1:0] req_be,
    output logic [31:0]      req_data,
    output logic             req_fault,

    input  logic [1:0]       rsp_size,
    input  logic             rsp_unsigned,
    input  logic [1:0]       rsp_lane,
    input  logic [31:0]      rsp_word,
    output logic [31:0]      rsp_data
);

    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    assign req_fault = is_fault(req_size, req_lane);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        req_be   = '0;
        req_data = '0;
        case (req_size)
            SIZE_B: begin
                req_be   = 4'b0001 << req_lane;
                req_data = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                req_be   = req_lane[1] ? 4'b1100 : 4'b0011;
                req_data = {2{req_wdata[15:0]}};
            end
            SIZE_W: begin
                req_be   = 4'b1111;
                req_data = req_wdata;
            end
            default: ;
        endcase
        if (req_fault) begin
            req_be = '0;
        end
    end

    always_comb begin
        rsp_byte = rsp_word[{rsp_lane, 3'b000} +: 8];
        rsp_half = rsp_lane[1] ? rsp_word[31:16] : rsp_word[15:0];
        rsp_data = rsp_word;
        case (rsp_size)
            SIZE_B:  rsp_data = rsp_unsigned ? {24'b0, rsp_byte} : {{24{rsp_byte[7]}}, rsp_byte};
            SIZE_H:  rsp_data = rsp_unsigned ? {16'b0, rsp_half} : {{16{rsp_half[15]}}, rsp_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte/half/word data memory with valid/ready requests, pipelined responses and a post-reset clear.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]             mem_q [DEPTH];

    logic                    run;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [LANES-1:0]        st_be;
    logic [31:0]             st_data;
    logic                    st_fault;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [LANES-1:0]        mem_wbe;
    logic [31:0]             mem_wdata;

    logic [31:0]             rd_word_q;
    logic                    s1_valid_q, s1_valid_d;
    rsp_meta_t               s1_meta_q, s1_meta_d;
    logic [31:0]             s1_ext;
    logic [31:0]             s1_rdata;

    logic                    out_valid;
    logic                    out_fault;
    logic [31:0]             out_rdata;

    // Address bits above the array alias onto it, so they are deliberately dropped.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign run       = (state_q == ST_RUN) && !rst;
    assign req_ready = run;
    assign init_done = run;
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[ADDR_WIDTH+1:2];

    dmem_lane_align u_align (
        .req_size     (req_size),
        .req_lane     (req_addr[1:0]),
        .req_wdata    (req_wdata),
        .req_be       (st_be),
        .req_data     (st_data),
        .req_fault    (st_fault),
        .rsp_size     (s1_meta_q.size),
        .rsp_unsigned (s1_meta_q.uns),
        .rsp_lane     (s1_meta_q.lane),
        .rsp_word     (rd_word_q),
        .rsp_data     (s1_ext)
    );

    // The single write port is shared between the clear sweep and accepted stores.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = req_idx;
        mem_wbe   = st_be;
        mem_wdata = st_data;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q;
                    mem_wbe   = '1;
                    mem_wdata = '0;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = accept && req_write && !st_fault;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        s1_valid_d      = accept;
        s1_meta_d.load  = !req_write && !st_fault;
        s1_meta_d.fault = st_fault;
        s1_meta_d.size  = req_size;
        s1_meta_d.uns   = req_unsigned;
        s1_meta_d.lane  = req_addr[1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_meta_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_meta_q  <= s1_meta_d;
        end
    end

    // NOTE: the array and its read register have no reset; the clear sweep initialises contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (mem_wbe[k]) begin
                    mem_q[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
        if (accept) begin
            rd_word_q <= mem_q[req_idx];
        end
    end

    assign s1_rdata = s1_meta_q.load ? s1_ext : 32'h0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        s2_valid_q, s2_valid_d;
            logic        s2_fault_q, s2_fault_d;
            logic [31:0] s2_rdata_q, s2_rdata_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_fault_d = s1_meta_q.fault;
                s2_rdata_d = s1_rdata;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_fault_q <= 1'b0;
                    s2_rdata_q <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_fault_q <= s2_fault_d;
                    s2_rdata_q <= s2_rdata_d;
                end
            end

            assign out_valid = s2_valid_q;
            assign out_fault = s2_fault_q;
            assign out_rdata = s2_rdata_q;
        end else begin : g_lat1
            assign out_valid = s1_valid_q;
            assign out_fault = s1_meta_q.fault;
            assign out_rdata = s1_rdata;
        end
    endgenerate

    // Gating by rst keeps responses silent during reset even before the first reset edge.
    assign resp_valid = out_valid && !rst;
    assign resp_fault = resp_valid && out_fault;
    assign resp_rdata = resp_valid ? out_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: two controllers (latency 1 and 2) against a byte-array reference model.
module tb_dmem_ctrl;

    localparam int AW     = 4;
    localparam int NBYTES = 4 * (2 ** AW);
    localparam int NWORDS = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy  [2];
    logic        rv   [2];
    logic [31:0] rd   [2];
    logic        rf   [2];
    logic        done [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[0]),
        .resp_rdata(rd[0]), .resp_fault(rf[0]), .init_done(done[0])
    );

    dmem_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[1]),
        .resp_rdata(rd[1]), .resp_fault(rf[1]), .init_done(done[1])
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [7:0]  mem_m [NBYTES];
    req_t        bq    [$];
    logic [31:0] exp_d [$];
    logic        exp_f [$];

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
    endfunction

    function automatic void model(input req_t r, output logic f, output logic [31:0] d);
        int          base;
        int          nb;
        logic [31:0] w;
        f = (r.size == 2'b11) || (r.size == 2'b01 && r.addr[0]) ||
            (r.size == 2'b10 && r.addr[1:0] != 2'b00);
        d = 32'h0;
        if (f) return;
        base = int'(r.addr[AW+1:0]);
        nb   = (r.size == 2'b00) ? 1 : (r.size == 2'b01) ? 2 : 4;
        if (r.wr) begin
            for (int i = 0; i < nb; i++) mem_m[base + i] = r.wdata[8*i +: 8];
        end else begin
            w = 32'h0;
            for (int i = 0; i < nb; i++) w[8*i +: 8] = mem_m[base + i];
            if (!r.uns && nb < 4 && w[8*nb-1]) w = w | ~((32'd1 << (8*nb)) - 32'd1);
            d = w;
        end
    endfunction

    task automatic push(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.wr = wr; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        bq.push_back(r);
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
    endtask

    // Drives the queued requests on consecutive cycles; called at a negedge, returns at a negedge.
    task automatic run_burst(input string tag);
        int          n;
        int          idx;
        logic        f;
        logic [31:0] d;
        n = bq.size();
        exp_d.delete();
        exp_f.delete();
        for (int i = 0; i < n; i++) begin
            model(bq[i], f, d);
            exp_d.push_back(d);
            exp_f.push_back(f);
        end
        for (int s = 0; s <= n + 2; s++) begin
            for (int u = 0; u < 2; u++) begin
                idx = s - (u + 1);
                if (s == 0) begin
                    n_cmp++;
                    if (rdy[u] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL %s dut%0d ready: got %b want 1", tag, u, rdy[u]);
                    end
                end else begin
                    n_cmp++;
                    if (rv[u] !== (idx >= 0 && idx < n)) begin
                        n_bad++;
                        $display("FAIL %s dut%0d step%0d resp_valid: got %b want %b",
                                 tag, u, s, rv[u], (idx >= 0 && idx < n));
                    end else if (idx >= 0 && idx < n) begin
                        n_cmp++;
                        if (rd[u] !== exp_d[idx] || rf[u] !== exp_f[idx]) begin
                            n_bad++;
                            $display("FAIL %s dut%0d req%0d rdata/fault: got %h/%b want %h/%b",
                                     tag, u, idx, rd[u], rf[u], exp_d[idx], exp_f[idx]);
                        end
                    end
                end
            end
            if (s < n) begin
                req_valid    = 1'b1;
                req_write    = bq[s].wr;
                req_size     = bq[s].size;
                req_unsigned = bq[s].uns;
                req_addr     = bq[s].addr;
                req_wdata    = bq[s].wdata;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        bq.delete();
    endtask

    // Called at the negedge where rst falls; init must finish after exactly NWORDS edges.
    task automatic wait_init(input string tag);
        int k_done [2];
        k_done[0] = 0;
        k_done[1] = 0;
        model_clear();
        for (int k = 1; k <= NWORDS + 8; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (k_done[u] == 0 && done[u] === 1'b1) k_done[u] = k;
            end
        end
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (k_done[u] != NWORDS) begin
                n_bad++;
                $display("FAIL %s dut%0d init cycles: got %0d want %0d", tag, u, k_done[u], NWORDS);
            end
        end
    endtask

    task automatic do_reset(input string tag, input int cycles);
        rst = 1'b1;
        idle_inputs();
        for (int c = 0; c < cycles; c++) begin
            #1;
            for (int u = 0; u < 2; u++) begin
                n_cmp++;
                if ({rdy[u], done[u], rv[u], rf[u], rd[u]} !== 36'h0) begin
                    n_bad++;
                    $display("FAIL %s dut%0d outputs in reset: got %b%b%b%b/%h want all zero",
                             tag, u, rdy[u], done[u], rv[u], rf[u], rd[u]);
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
        wait_init(tag);
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset("reset", 3);
    endtask

    task automatic test_reset_clear();
        push(1, 2'b10, 0, 32'h14, 32'hDEADBEEF);
        push(0, 2'b10, 0, 32'h14, 32'h0);
        run_burst("preload");
        do_reset("reclear", 1);
        push(0, 2'b10, 0, 32'h14, 32'h0);
        run_burst("after_clear");
    endtask

    task automatic test_byte_half();
        push(1, 2'b10, 0, 32'h20, 32'h11223344);
        push(1, 2'b00, 0, 32'h21, 32'h000000AA);
        push(1, 2'b01, 0, 32'h22, 32'h0000BEEF);
        push(0, 2'b10, 0, 32'h20, 32'h0);
        run_burst("byte_half");
    endtask

    task automatic test_extension();
        push(1, 2'b10, 0, 32'h30, 32'h80FF7F01);
        push(0, 2'b00, 0, 32'h33, 32'h0);
        push(0, 2'b00, 1, 32'h33, 32'h0);
        push(0, 2'b01, 0, 32'h32, 32'h0);
        push(0, 2'b01, 1, 32'h30, 32'h0);
        push(0, 2'b00, 1, 32'h31, 32'h0);
        push(0, 2'b10, 1, 32'h30, 32'h0);
        run_burst("extension");
    endtask

    task automatic test_faults();
        push(0, 2'b10, 0, 32'h22, 32'h0);
        push(1, 2'b01, 0, 32'h31, 32'h0000FFFF);
        push(1, 2'b11, 0, 32'h0,  32'hFFFFFFFF);
        push(1, 2'b10, 0, 32'h26, 32'hFFFFFFFF);
        push(0, 2'b10, 0, 32'h30, 32'h0);
        push(0, 2'b10, 0, 32'h0,  32'h0);
        push(0, 2'b10, 0, 32'h24, 32'h0);
        run_burst("faults");
    endtask

    task automatic test_back_to_back();
        push(1, 2'b10, 0, 32'h0, 32'h00000005);
        push(0, 2'b10, 0, 32'h0, 32'h0);
        push(0, 2'b10, 0, 32'h4, 32'h0);
        run_burst("back_to_back");
    endtask

    task automatic test_wrap();
        push(1, 2'b10, 0, 32'h40,       32'h00000077);
        push(0, 2'b10, 0, 32'h0,        32'h0);
        push(1, 2'b00, 0, 32'hFFFFFFC5, 32'h0000009C);
        push(0, 2'b00, 0, 32'h5,        32'h0);
        run_burst("wrap");
    endtask

    task automatic test_random();
        int   n;
        int   r;
        req_t q;
        for (int b = 0; b < 40; b++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                q.size  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                q.wr    = $urandom_range(0, 1);
                q.uns   = $urandom_range(0, 1);
                q.addr  = $urandom;
                q.wdata = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (q.size == 2'b01) q.addr[0] = 1'b0;
                    if (q.size == 2'b10) q.addr[1:0] = 2'b00;
                end
                push(q.wr, q.size, q.uns, q.addr, q.wdata);
            end
            run_burst("random");
        end
    endtask

    task automatic test_midop_reset();
        push(1, 2'b10, 0, 32'h30, 32'hCAFEF00D);
        run_burst("midop_setup");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h30;
        @(negedge clk);
        rst       = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h8;
        req_wdata = 32'h12345678;
        #1;
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (rv[u] !== 1'b0) begin
                n_bad++;
                $display("FAIL midop dut%0d resp_valid at reset: got %b want 0", u, rv[u]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int k = 1; k <= NWORDS; k++) begin
            @(negedge clk);
            if (k == NWORDS) req_valid = 1'b0;
            for (int u = 0; u < 2; u++) begin
                n_cmp++;
                if (rv[u] !== 1'b0 || done[u] !== (k == NWORDS)) begin
                    n_bad++;
                    $display("FAIL midop dut%0d cycle%0d valid/done: got %b/%b want 0/%b",
                             u, k, rv[u], done[u], (k == NWORDS));
                end
            end
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                n_cmp++;
                if (rv[u] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midop dut%0d stray resp_valid: got %b want 0", u, rv[u]);
                end
            end
        end
        push(0, 2'b10, 0, 32'h8,  32'h0);
        push(0, 2'b10, 0, 32'h30, 32'h0);
        run_burst("midop_after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_reset_clear();
        test_byte_half();
        test_extension();
        test_faults();
        test_back_to_back();
        test_wrap();
        test_random();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
